// File: rtl/bp_be_fe_queue_buffer.sv
// Speculative FE-to-BE fetch queue buffer.
// Packets are read ahead of a commit checkpoint so that read-but-uncommitted
// entries can be replayed by rewinding the read pointer. A clear discards all
// entries. Pointers carry one extra wrap bit to tell full from empty.

module bp_be_fe_queue_buffer_checker #(
   parameter int ptr_width_p = 3
)(
   input logic                   clk_i,
   input logic                   reset_i,
   input logic                   deq_i,
   input logic                   commit_i,
   input logic                   fe_queue_v_o,
   input logic [ptr_width_p:0]   cptr_i,
   input logic [ptr_width_p:0]   rptr_i
);

   // The issue stage may only consume a valid entry.
   deq_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      deq_i |-> fe_queue_v_o);

   // A commit needs a read-but-uncommitted entry, or one read this cycle.
   commit_only_when_read: assert property (@(posedge clk_i) disable iff (reset_i)
      commit_i |-> ((cptr_i != rptr_i) || deq_i));

endmodule

module bp_be_fe_queue_buffer #(
   // 0 selects the default processor configuration (e_bp_default_cfg)
   parameter int  bp_params_p       = 0,
   parameter int  els_p             = 8,
   localparam int fe_queue_width_lp = (bp_params_p == 0) ? 64 : 96,
   localparam int ptr_width_lp      = $clog2(els_p)
)(
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic [fe_queue_width_lp-1:0] fe_queue_i,
   input  logic                         fe_queue_v_i,
   output logic                         fe_queue_ready_and_o,

   output logic [fe_queue_width_lp-1:0] fe_queue_o,
   output logic                         fe_queue_v_o,
   input  logic                         deq_i,

   input  logic                         commit_i,
   input  logic                         roll_i,
   input  logic                         clr_i,
   output logic                         empty_o
);

   localparam logic [ptr_width_lp:0] ptr_zero_lp = {(ptr_width_lp+1){1'b0}};

   logic [fe_queue_width_lp-1:0] mem_r [els_p];

   logic [ptr_width_lp:0] wptr_r, rptr_r, cptr_r;
   logic [ptr_width_lp:0] wptr_n_s, rptr_n_s, cptr_n_s;
   logic                  full_s;
   logic                  enq_s;

   // Full when write and commit pointers share an index but differ in wrap.
   always_comb begin
      full_s = (wptr_r[ptr_width_lp-1:0] == cptr_r[ptr_width_lp-1:0])
             & (wptr_r[ptr_width_lp] != cptr_r[ptr_width_lp]);
      enq_s  = fe_queue_v_i & ~full_s;
   end

   // Next-pointer selection: clear beats roll, roll rewinds to the post-commit checkpoint.
   always_comb begin
      wptr_n_s = wptr_r;
      rptr_n_s = rptr_r;
      cptr_n_s = cptr_r;
      if (clr_i) begin
         wptr_n_s = ptr_zero_lp;
         rptr_n_s = ptr_zero_lp;
         cptr_n_s = ptr_zero_lp;
      end else begin
         wptr_n_s = wptr_r + {{ptr_width_lp{1'b0}}, enq_s};
         cptr_n_s = cptr_r + {{ptr_width_lp{1'b0}}, commit_i};
         if (roll_i) begin
            // same-cycle deq is dropped; replay restarts at the checkpoint
            rptr_n_s = cptr_n_s;
         end else begin
            rptr_n_s = rptr_r + {{ptr_width_lp{1'b0}}, deq_i};
         end
      end
   end

   // Pointer registers with asynchronous reset to the empty state.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_r <= ptr_zero_lp;
         rptr_r <= ptr_zero_lp;
         cptr_r <= ptr_zero_lp;
      end else begin
         wptr_r <= wptr_n_s;
         rptr_r <= rptr_n_s;
         cptr_r <= cptr_n_s;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (enq_s & ~clr_i) begin
         mem_r[wptr_r[ptr_width_lp-1:0]] <= fe_queue_i;
      end
   end

   // Outputs are decoded purely from registered state, never from inputs.
   always_comb begin
      fe_queue_ready_and_o = ~full_s;
      fe_queue_v_o         = (rptr_r != wptr_r);
      fe_queue_o           = mem_r[rptr_r[ptr_width_lp-1:0]];
      empty_o              = (cptr_r == wptr_r);
   end

   bp_be_fe_queue_buffer_checker #(
      .ptr_width_p (ptr_width_lp)
   ) checker_i (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .deq_i        (deq_i),
      .commit_i     (commit_i),
      .fe_queue_v_o (fe_queue_v_o),
      .cptr_i       (cptr_r),
      .rptr_i       (rptr_r)
   );

endmodule
